// File: rtl/burt_v_window_ctrl.sv
// Vertical 5x1 window generator over a raster-order FP16 pixel stream using four circular line buffers.
// Build option BURT_V_ZERO_PAD_EN: out-of-frame taps read as +0.0 instead of replicating the nearest edge row.
module burt_v_window_ctrl #(
   parameter int EXP_WIDTH     = 5,
   parameter int FRAC_WIDTH    = 10,
   parameter int IMAGE_WIDTH   = 640,
   parameter int IMAGE_HEIGHT  = 480,
   localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [FP_WIDTH_REG-1:0] data_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [FP_WIDTH_REG-1:0] window_o [5][1],
   output logic [15:0]             col_o,
   output logic [15:0]             row_o,
   output logic                    valid_o,
   output logic                    frame_done_o
);
   localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
   localparam logic signed [17:0] MAX_ROW = 18'(IMAGE_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [15:0]             col_q, col_d;
   logic [15:0]             row_q, row_d;
   logic                    flush_hi_q, flush_hi_d;
   logic                    accept, last_col, last_row;
   logic                    emit, emit_fd;
   logic [16:0]             ctr_row;
   logic [CW-1:0]           col_idx;
   logic signed [17:0]      tap_raw [5];
   logic signed [17:0]      tap_src [5];
   logic [FP_WIDTH_REG-1:0] tap_dat [5];
   logic [FP_WIDTH_REG-1:0] lb_q [4][IMAGE_WIDTH];
   logic [FP_WIDTH_REG-1:0] win_q [5];
   logic [15:0]             ocol_q, orow_q;
   logic                    vld_q, fd_q;

   assign ready_o  = !rst_i && (state_q != FLUSH);
   assign accept   = valid_i && ready_o;
   assign last_col = (col_q == LAST_COL);
   assign last_row = (row_q == LAST_ROW);
   assign col_idx  = col_q[CW-1:0];

   // Centre row: two rows behind the input while streaming, the last two rows while flushing.
   assign ctr_row = (state_q == FLUSH) ? 17'(IMAGE_HEIGHT - 2) + {16'd0, flush_hi_q}
                                       : {1'b0, row_q} - 17'd2;

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         tap_raw[k] = $signed({1'b0, ctr_row}) + $signed(18'(k)) - 18'sd2;
         if (tap_raw[k] < 18'sd0)
            tap_src[k] = 18'sd0;
         else if (tap_raw[k] > MAX_ROW)
            tap_src[k] = MAX_ROW;
         else
            tap_src[k] = tap_raw[k];
         // The newest row is not in a buffer yet; take it straight from the input.
         if ((state_q != FLUSH) && (tap_src[k] == $signed({2'b00, row_q})))
            tap_dat[k] = data_i;
         else
            tap_dat[k] = lb_q[tap_src[k][1:0]][col_idx];
`ifdef BURT_V_ZERO_PAD_EN
         if ((tap_raw[k] < 18'sd0) || (tap_raw[k] > MAX_ROW))
            tap_dat[k] = '0;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      flush_hi_d = flush_hi_q;
      emit       = 1'b0;
      emit_fd    = 1'b0;
      case (state_q)
         IDLE, FILL, STREAM: begin
            if (accept) begin
               emit = (row_q >= 16'd2);
               if (last_col) begin
                  col_d = '0;
                  row_d = last_row ? 16'd0 : row_q + 16'd1;
               end else begin
                  col_d = col_q + 16'd1;
               end
               if (last_col && last_row) begin
                  state_d    = FLUSH;
                  flush_hi_d = 1'b0;
               end else if ((col_q == 16'd0) && (row_q == 16'd2)) begin
                  state_d = STREAM;
               end else if (state_q == IDLE) begin
                  state_d = FILL;
               end
            end
         end
         FLUSH: begin
            emit    = 1'b1;
            emit_fd = flush_hi_q && last_col;
            if (last_col) begin
               col_d = '0;
               if (flush_hi_q) begin
                  state_d    = IDLE;
                  flush_hi_d = 1'b0;
               end else begin
                  flush_hi_d = 1'b1;
               end
            end else begin
               col_d = col_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         col_q      <= '0;
         row_q      <= '0;
         flush_hi_q <= 1'b0;
         vld_q      <= 1'b0;
         fd_q       <= 1'b0;
         ocol_q     <= '0;
         orow_q     <= '0;
         for (int k = 0; k < 5; k++) win_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         flush_hi_q <= flush_hi_d;
         vld_q      <= emit;
         fd_q       <= emit_fd;
         if (emit) begin
            for (int k = 0; k < 5; k++) win_q[k] <= tap_dat[k];
            ocol_q <= col_q;
            orow_q <= ctr_row[15:0];
         end
      end
   end

   // Row r lives in buffer r mod 4; contents survive reset and are rewritten before reuse.
   always_ff @(posedge clk_i) begin
      if (accept) lb_q[row_q[1:0]][col_idx] <= data_i;
   end

   always_comb begin
      for (int k = 0; k < 5; k++) window_o[k][0] = win_q[k];
   end

   assign col_o        = ocol_q;
   assign row_o        = orow_q;
   assign valid_o      = vld_q;
   assign frame_done_o = fd_q;

endmodule

// File: doc/burt_v_window_ctrl.md
BURT_V_WINDOW_CTRL -- requirements
Module: burt_v_window_ctrl

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, the FP16 exponent width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, the FP16 fraction width; FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 640, pixels per row; legal range 1..65535.
REQ-004 SHALL have parameter IMAGE_HEIGHT, default 480, rows per frame; legal range 3..65535.
REQ-005 Ports: clk_i  in  1  the single clock; all logic runs on its rising edge.
REQ-006 Ports: rst_i  in  1  asynchronous, active-high reset.
REQ-007 Ports: data_i  in  FP_WIDTH_REG  raster-order input pixel.
REQ-008 Ports: valid_i  in  1  data_i is present; a pixel is accepted when valid_i && ready_o.
REQ-009 Ports: ready_o  out  1  the block can accept a pixel this cycle.
REQ-010 Ports: window_o  out  [5][1] x FP_WIDTH_REG  vertical 5x1 window; [0] = row r-2 ... [4] = row r+2.
REQ-011 Ports: col_o, row_o  out  16 each  coordinates of the window centre pixel.
REQ-012 Ports: valid_o  out  1  window_o/col_o/row_o are valid; one-cycle qualifier.
REQ-013 Ports: frame_done_o  out  1  single-cycle pulse with the last window of a frame.

Function
REQ-014 SHALL hold 4 line buffers of IMAGE_WIDTH x FP_WIDTH_REG, written circularly, one row per buffer.
REQ-015 SHALL track input col/row counters; col wraps IMAGE_WIDTH-1 -> 0 and increments row; row wraps IMAGE_HEIGHT-1 -> 0 at frame end.
REQ-016 FSM states SHALL be IDLE, FILL, STREAM, FLUSH.
REQ-017 IDLE -> FILL on first accepted pixel; FILL covers input rows 0..1; no windows are emitted in FILL.
REQ-018 FILL -> STREAM on acceptance of pixel (0,2); in STREAM each accepted pixel (c,r) emits the window centred on (c,r-2).
REQ-019 STREAM -> FLUSH on acceptance of pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
REQ-020 In FLUSH ready_o SHALL be 0; the block emits rows IMAGE_HEIGHT-2 and IMAGE_HEIGHT-1 at one window per cycle (2*IMAGE_WIDTH cycles), then returns to IDLE.
REQ-021 ready_o SHALL be 1 in IDLE, FILL and STREAM.
REQ-022 Latency: valid_o SHALL assert exactly 1 cycle after the accepting edge of the triggering pixel (STREAM) or after the FLUSH step.
REQ-023 Border: out-of-frame taps (row < 0 or row > IMAGE_HEIGHT-1) SHALL replicate the nearest in-frame row (row 0 or IMAGE_HEIGHT-1).
REQ-024 frame_done_o SHALL assert in the same cycle as valid_o for window (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
REQ-025 valid_i low in IDLE/FILL/STREAM SHALL stall all counters and the FSM; no output is produced.
REQ-026 Pixel data SHALL pass through unmodified (bit-exact); no arithmetic on data.
REQ-027 IMAGE_HEIGHT = 3: FILL -> STREAM at (0,2), STREAM emits row 0 only, FLUSH emits rows 1 and 2.

Reset
REQ-028 On rst_i high: FSM = IDLE, counters = 0, valid_o = 0, frame_done_o = 0, window_o = 0, col_o = row_o = 0, ready_o = 0 while rst_i is asserted.
REQ-029 Reset mid-frame SHALL discard the partial frame; line buffer contents need not be cleared; the next accepted pixel is treated as (0,0).

Configuration
REQ-030 Macro BURT_V_ZERO_PAD_EN defined: out-of-frame taps SHALL be all-zero (+0.0, 16'h0000) instead of replicated.
REQ-031 Macro BURT_V_ZERO_PAD_EN undefined: replicate border per REQ-023.

Verification
REQ-032 4x4 frame, pixel = 16'h(row*16+col), valid_i always 1 -> 16 windows; (0,0) window = {00,00,00,10,20}; ready_o low for exactly 8 cycles.
REQ-033 Same frame with BURT_V_ZERO_PAD_EN -> (0,0) window = {0000,0000,0000,0010,0020}; (3,3) window = {0013,0023,0033,0000,0000}.
REQ-034 Random valid_i (50% duty) on 8x5 frame -> output sequence identical to the no-gap run; no valid_o while valid_i is held low in STREAM.
REQ-035 rst_i pulsed after 10 pixels of a 4x4 frame, then a full frame -> exactly 16 windows with correct coordinates and frame_done_o once.
REQ-036 Width 3, height 3, back-to-back frames -> frame_done_o at window (2,2); second frame's first pixel accepted the cycle after FLUSH ends.
